// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and constants for the load/store unit.
// Contents: data width, lane widths, access-size codes, FSM state encoding,
// and the misalignment predicate used by the optional trap (LSU_MISALIGN_TRAP_EN).
package lsu_pkg;
  localparam int WIDTH  = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;
  // size 2'b11 behaves as a word, so size[1] marks any word access
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_H && off[0]) || (size[1] && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus data-memory port-1 write and port-a read.
// Signals: req_valid/req_ready/req_wen/req_size/req_unsigned/req_addr/req_wdata,
// resp_valid/resp_rdata/resp_err, mem_wen/mem_addrw/mem_dataw, mem_ren/mem_addr/mem_rdata.
// Modports: slave = the lsu, master = the execute stage plus memory side.
interface lsu_if;
  import lsu_pkg::*;
  logic             req_valid;
  logic             req_ready;
  logic             req_wen;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_addrw;
  logic [WIDTH-1:0] mem_dataw;
  logic             mem_ren;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_wen, mem_addrw, mem_dataw, mem_ren, mem_addr
  );
  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_wen, mem_addrw, mem_dataw, mem_ren, mem_addr
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the lsu.
// Ports: word (memory word), wdata (low-aligned store data), off (addr[1:0]),
// size, uns (zero-extend) -> load (extended load result), merged (read-modify-write word).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       off,
  input  logic [1:0]       size,
  input  logic             uns,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] merged
);
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  ins;
  always_comb begin
    b = word[{off, 3'b000} +: BYTE_W];
    h = word[{off[1], 4'b0000} +: HALF_W];
    load = size == SZ_B ? {{(WIDTH-BYTE_W){~uns & b[BYTE_W-1]}}, b}
         : size == SZ_H ? {{(WIDTH-HALF_W){~uns & h[HALF_W-1]}}, h}
         : word;
    // replicate the store lane everywhere, then keep only the addressed lane
    mask = size == SZ_B ? WIDTH'(8'hFF) << {off, 3'b000}
         : size == SZ_H ? WIDTH'(16'hFFFF) << {off[1], 4'b0000}
         : {WIDTH{1'b1}};
    ins = size == SZ_B ? {4{wdata[BYTE_W-1:0]}}
        : size == SZ_H ? {2{wdata[HALF_W-1:0]}}
        : wdata;
    merged = (word & ~mask) | (ins & mask);
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and data memory; one request at a time.
// Ports: clk, rst (synchronous, active-low), bus (lsu_if.slave: request/response
// handshake, memory port-1 write, memory port-a read).
// Option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses complete at once
// with resp_err = 1 and no memory access; otherwise misalignment is ignored.
module lsu
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  state_t           state, nxt;
  logic             acc, trap;
  logic             wen, uns, err;
  logic [1:0]       size;
  logic [WIDTH-1:0] addr, wdata, rdata, wbuf, load, merged;
  assign acc = rst && bus.req_valid && state == S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif
  lsu_align u_align (
    .word  (bus.mem_rdata),
    .wdata (wdata),
    .off   (addr[1:0]),
    .size  (size),
    .uns   (uns),
    .load  (load),
    .merged(merged)
  );
  always_ff @(posedge clk)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  // wbuf holds the word to write: raw data for word stores, merged word otherwise
  always_ff @(posedge clk)
    if (!rst) begin
      {wen, uns, err, size} <= '0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      wbuf  <= '0;
    end else begin
      if (acc) begin
        wen   <= bus.req_wen;
        size  <= bus.req_size;
        uns   <= bus.req_unsigned;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        wbuf  <= bus.req_wdata;
        rdata <= '0;
        err   <= trap;
      end
      if (state == S_WAIT) begin
        if (wen) wbuf <= merged;
        else rdata <= load;
      end
    end
  // every output is gated by rst so nothing leaks while reset is held
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = !acc ? S_IDLE : trap ? S_DONE : (bus.req_wen && bus.req_size[1]) ? S_WR : S_RD;
      S_RD:    nxt = S_WAIT;
      S_WAIT:  nxt = wen ? S_WR : S_DONE;
      S_WR:    nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
    bus.req_ready  = rst && state == S_IDLE;
    bus.mem_ren    = rst && state == S_RD;
    bus.mem_wen    = rst && state == S_WR;
    bus.resp_valid = rst && state == S_DONE;
    bus.mem_addr   = rst ? {addr[WIDTH-1:2], 2'b00} : '0;
    bus.mem_addrw  = rst ? {addr[WIDTH-1:2], 2'b00} : '0;
    bus.mem_dataw  = rst ? wbuf : '0;
    bus.resp_rdata = bus.resp_valid ? rdata : '0;
    bus.resp_err   = bus.resp_valid && err;
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a byte-addressed reference memory model.
module tb_lsu;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  lsu_if bus ();
  lsu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (bus.mem_wen) mem[bus.mem_addrw[9:2]] <= bus.mem_dataw;
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end
  logic [7:0]  ref_bytes [0:1023];
  int          e_ren, e_wen, e_resp;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_err;
  int          o_ren, o_wen, o_resp, o_nren, o_nwen;
  logic [31:0] o_ren_a, o_wen_a, o_wen_d, o_rdata;
  logic        o_err, o_rdy, o_rdy_bad, o_clash;

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = a[9:2]; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[int'(a[9:2]) * 4 + i] = d[8*i +: 8];
  endtask

  // reference: memory as bytes; a request touches n consecutive bytes from its lane start
  task automatic ref_op(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int n, st, base;
    logic trap;
    logic [31:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    st = int'(a[9:0]);
    if (n == 2) st = st & ~1;
    if (n == 4) st = st & ~3;
    base = st & ~3;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    e_addr = a & ~32'h3; e_err = trap; e_rdata = '0; e_wdata = '0;
    if (trap) begin
      e_ren = 0; e_wen = 0; e_resp = 1;
    end else if (!w) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(ref_bytes[st + i]) << (8 * i);
      if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      e_rdata = v; e_ren = 1; e_wen = 0; e_resp = 3;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[st + i] = d[8*i +: 8];
      for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = ref_bytes[base + i];
      e_ren = n == 4 ? 0 : 1; e_wen = n == 4 ? 1 : 3; e_resp = n == 4 ? 2 : 4;
    end
  endtask

  // drive one request and record, per cycle after acceptance, what the DUT shows
  task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    o_ren = 0; o_wen = 0; o_resp = 0; o_nren = 0; o_nwen = 0;
    o_rdata = 'x; o_err = 1'bx; o_rdy_bad = 1'b0; o_clash = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = d;
    #1 o_rdy = bus.req_ready;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0; bus.req_wen = 1'($urandom); bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
      end
      #1;
      if (bus.mem_ren) begin o_nren++; o_ren = k; o_ren_a = bus.mem_addr; end
      if (bus.mem_wen) begin o_nwen++; o_wen = k; o_wen_a = bus.mem_addrw; o_wen_d = bus.mem_dataw; end
      if (bus.mem_ren && bus.mem_wen) o_clash = 1'b1;
      if (bus.req_ready) o_rdy_bad = 1'b1;
      if (bus.resp_valid) begin o_resp = k; o_rdata = bus.resp_rdata; o_err = bus.resp_err; break; end
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wen, bus.mem_ren} !== 5'b0 ||
          {bus.resp_rdata, bus.mem_addr, bus.mem_addrw, bus.mem_dataw} !== 128'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: ready=%b resp=%b ren=%b wen=%b, required all 0",
                 k, bus.req_ready, bus.resp_valid, bus.mem_ren, bus.mem_wen);
      end
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_loads;
    logic [31:0] ta [6] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h102, 32'h100};
    logic [1:0]  ts [6] = '{SZ_B, SZ_B, SZ_B, SZ_H, SZ_H, SZ_H};
    logic        tu [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tx [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0050,
                            32'hFFFF_8070, 32'h0000_8070, 32'h0000_6050};
    preload(32'h100, 32'h8070_6050);
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, ts[i], tu[i], ta[i], $urandom);
      checks++;
      if (o_rdata !== tx[i] || o_err !== 1'b0) begin
        failures++; $display("FAIL load_data[%0d] got %h err %b required %h err 0", i, o_rdata, o_err, tx[i]);
      end
      checks++;
      if (o_ren != 1 || o_nren != 1 || o_nwen != 0 || o_resp != 3) begin
        failures++;
        $display("FAIL load_timing[%0d] ren@%0d x%0d wen x%0d resp@%0d required ren@1 x1 wen x0 resp@3",
                 i, o_ren, o_nren, o_nwen, o_resp);
      end
      checks++;
      if (o_ren_a !== 32'h100) begin
        failures++; $display("FAIL load_addr[%0d] got %h required 00000100", i, o_ren_a);
      end
    end
  endtask

  task automatic test_word_store;
    preload(32'h104, 32'h0);
    run_op(1'b1, SZ_W, 1'b0, 32'h104, 32'hDEAD_BEEF);
    checks++;
    if (o_wen != 1 || o_nwen != 1 || o_nren != 0 || o_resp != 2) begin
      failures++;
      $display("FAIL sw_timing wen@%0d x%0d ren x%0d resp@%0d required wen@1 x1 ren x0 resp@2",
               o_wen, o_nwen, o_nren, o_resp);
    end
    checks++;
    if (o_wen_a !== 32'h104 || o_wen_d !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL sw_write got %h<=%h required 00000104<=deadbeef", o_wen_a, o_wen_d);
    end
    checks++;
    if (o_rdata !== 32'h0 || o_err !== 1'b0) begin
      failures++; $display("FAIL sw_resp got rdata %h err %b required 0 0", o_rdata, o_err);
    end
    run_op(1'b0, SZ_W, 1'b0, 32'h104, 32'h0);
    checks++;
    if (o_rdata !== 32'hDEAD_BEEF || o_resp != 3) begin
      failures++; $display("FAIL lw_after_sw got %h resp@%0d required deadbeef resp@3", o_rdata, o_resp);
    end
  endtask

  task automatic test_subword_store;
    logic [31:0] ta [2] = '{32'h101, 32'h102};
    logic [1:0]  ts [2] = '{SZ_B, SZ_H};
    logic [31:0] td [2] = '{32'h0000_00AA, 32'h0000_1234};
    logic [31:0] tx [2] = '{32'h8070_AA50, 32'h1234_6050};
    for (int i = 0; i < 2; i++) begin
      preload(32'h100, 32'h8070_6050);
      run_op(1'b1, ts[i], 1'b0, ta[i], td[i]);
      checks++;
      if (o_ren != 1 || o_nren != 1 || o_wen != 3 || o_nwen != 1 || o_resp != 4 || o_clash) begin
        failures++;
        $display("FAIL rmw_timing[%0d] ren@%0d x%0d wen@%0d x%0d resp@%0d required ren@1 x1 wen@3 x1 resp@4",
                 i, o_ren, o_nren, o_wen, o_nwen, o_resp);
      end
      checks++;
      if (o_wen_a !== 32'h100 || o_wen_d !== tx[i]) begin
        failures++; $display("FAIL rmw_write[%0d] got %h<=%h required 00000100<=%h", i, o_wen_a, o_wen_d, tx[i]);
      end
      checks++;
      if (o_rdata !== 32'h0 || o_err !== 1'b0) begin
        failures++; $display("FAIL rmw_resp[%0d] got rdata %h err %b required 0 0", i, o_rdata, o_err);
      end
    end
  endtask

  task automatic test_misaligned;
    preload(32'h100, 32'h8070_6050);
    run_op(1'b0, SZ_W, 1'b0, 32'h102, 32'h0);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (o_resp != 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_nren != 0 || o_nwen != 0) begin
      failures++;
      $display("FAIL misaligned_trap resp@%0d err %b rdata %h ren x%0d wen x%0d required resp@1 err 1 rdata 0 no strobes",
               o_resp, o_err, o_rdata, o_nren, o_nwen);
    end
`else
    if (o_resp != 3 || o_err !== 1'b0 || o_rdata !== 32'h8070_6050) begin
      failures++;
      $display("FAIL misaligned_lw resp@%0d err %b rdata %h required resp@3 err 0 rdata 80706050",
               o_resp, o_err, o_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    preload(32'h100, 32'h8070_6050);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'hAA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_wen, bus.mem_ren} !== 4'b0 || bus.mem_dataw !== 32'h0 ||
        bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs ready=%b resp=%b wen=%b ren=%b dataw=%h required all 0",
               bus.req_ready, bus.resp_valid, bus.mem_wen, bus.mem_ren, bus.mem_dataw);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      if (bus.mem_wen || bus.resp_valid) seen = 1'b1;
    end
    rst = 1'b1; #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ready got %b required 1", bus.req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (bus.mem_wen || bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rst_mid_abandon got strobe after reset required none");
    end
    run_op(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    checks++;
    if (o_rdata !== 32'h8070_6050) begin
      failures++; $display("FAIL rst_mid_mem got %h required 80706050", o_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic w, u;
    logic [1:0] sz;
    logic [31:0] a, d;
    for (int i = 0; i < 8; i++) preload(32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); u = 1'($urandom); sz = 2'($urandom);
      a = 32'h100 + 32'($urandom_range(0, 31)); d = $urandom;
      ref_op(w, sz, u, a, d);
      run_op(w, sz, u, a, d);
      checks++;
      if (o_ren != e_ren || o_wen != e_wen || o_resp != e_resp || o_nren > 1 || o_nwen > 1 || o_clash) begin
        failures++;
        $display("FAIL rand_timing[%0d] w%b sz%0d a=%h ren@%0d wen@%0d resp@%0d required ren@%0d wen@%0d resp@%0d",
                 i, w, sz, a, o_ren, o_wen, o_resp, e_ren, e_wen, e_resp);
      end
      checks++;
      if (o_rdata !== e_rdata || o_err !== e_err) begin
        failures++;
        $display("FAIL rand_resp[%0d] w%b sz%0d u%b a=%h got %h err %b required %h err %b",
                 i, w, sz, u, a, o_rdata, o_err, e_rdata, e_err);
      end
      checks++;
      if ((e_wen != 0 && (o_wen_a !== e_addr || o_wen_d !== e_wdata)) || (e_ren != 0 && o_ren_a !== e_addr)) begin
        failures++;
        $display("FAIL rand_mem[%0d] sz%0d a=%h rd %h wr %h<=%h required addr %h data %h",
                 i, sz, a, o_ren_a, o_wen_a, o_wen_d, e_addr, e_wdata);
      end
      checks++;
      if (o_rdy !== 1'b1 || o_rdy_bad !== 1'b0) begin
        failures++; $display("FAIL rand_ready[%0d] at accept %b busy-high %b required 1 0", i, o_rdy, o_rdy_bad);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_word_store();
    test_subword_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
